// File: rtl/isa_pkg.sv
// isa_pkg: instruction word format shared by the encoder (writer side) and the
// decode stage (reader side), so both ends agree on field placement.
//   - type codes, field bit positions, immediate limits, error codes
//   - field bundle struct and encoder FSM state type
package isa_pkg;

   typedef enum logic [1:0] {
      TYPE_R = 2'b00,
      TYPE_J = 2'b01,
      TYPE_I = 2'b10,
      TYPE_S = 2'b11
   } itype_e;

   // Field LSB positions inside the 32-bit word
   localparam int STOP_BIT  = 0;
   localparam int TYPE_LSB  = 1;
   localparam int IMM14_LSB = 3;
   localparam int IMM24_LSB = 3;
   localparam int SA_LSB    = 7;
   localparam int RS2_LSB   = 12;
   localparam int RD_LSB    = 17;
   localparam int RS1_LSB   = 22;
   localparam int FUNC_LSB  = 27;

   localparam int TYPE_W  = 2;
   localparam int REG_W   = 5;
   localparam int IMM14_W = 14;
   localparam int IMM24_W = 24;

   // Signed immediate limits (full 32-bit two's complement compare)
   localparam logic signed [31:0] IMM_I_MIN = -32'sd8192;
   localparam logic signed [31:0] IMM_I_MAX =  32'sd8191;
   localparam logic signed [31:0] IMM_J_MIN = -32'sd8388608;
   localparam logic signed [31:0] IMM_J_MAX =  32'sd8388607;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_IMM_I = 2'b01;
   localparam logic [1:0] ERR_IMM_J = 2'b10;
   localparam logic [1:0] ERR_CAP   = 2'b11;

   typedef struct packed {
      itype_e           itype;
      logic [REG_W-1:0] func;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] sa;
      logic [31:0]      imm;
      logic             stop;
   } instr_fields_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10,
      S_ERR  = 2'b11
   } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational field packer.
//   f         : field bundle (type, func, regs, sa, imm, stop)
//   word      : packed 32-bit instruction word
//   imm_i_err : I-type immediate outside its signed 14-bit range
//   imm_j_err : J-type immediate outside its signed 24-bit range
module instr_pack
   import isa_pkg::*;
(
   input  instr_fields_t f,
   output logic [31:0]   word,
   output logic          imm_i_err,
   output logic          imm_j_err
);

   always_comb begin
      word                      = '0;
      word[STOP_BIT]            = f.stop;
      word[TYPE_LSB +: TYPE_W]  = f.itype;
      word[FUNC_LSB +: REG_W]   = f.func;
      case (f.itype)
         TYPE_R: begin
            word[RS1_LSB +: REG_W] = f.rs1;
            word[RD_LSB  +: REG_W] = f.rd;
            word[RS2_LSB +: REG_W] = f.rs2;
         end
         TYPE_J: begin
            word[IMM24_LSB +: IMM24_W] = f.imm[IMM24_W-1:0];
         end
         TYPE_I: begin
            word[RS1_LSB   +: REG_W]   = f.rs1;
            word[RD_LSB    +: REG_W]   = f.rd;
            word[IMM14_LSB +: IMM14_W] = f.imm[IMM14_W-1:0];
         end
         TYPE_S: begin
            word[RS1_LSB +: REG_W] = f.rs1;
            word[RD_LSB  +: REG_W] = f.rd;
            word[RS2_LSB +: REG_W] = f.rs2;
            word[SA_LSB  +: REG_W] = f.sa;
         end
      endcase
   end

   assign imm_i_err = (f.itype == TYPE_I) &&
                      (($signed(f.imm) < IMM_I_MIN) || ($signed(f.imm) > IMM_I_MAX));
   assign imm_j_err = (f.itype == TYPE_J) &&
                      (($signed(f.imm) < IMM_J_MIN) || ($signed(f.imm) > IMM_J_MAX));

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts field bundles over valid/ready, packs them and writes
// the words one cycle later to sequential instruction-memory addresses.
//   clk, reset          : clock, async active-high reset
//   start, base_addr    : open a session at base_addr (ignored while running)
//   in_valid/in_ready   : field bundle handshake; in_* : bundle fields
//   mem_we/addr/wdata   : one-cycle write strobe, address, encoded word
//   count               : words written this session
//   busy/done/err       : session running / ended by stop / aborted
//   err_code            : 00 none, 01 I-imm, 10 J-imm, 11 capacity
module instr_encoder
   import isa_pkg::*;
#(
   parameter int ADDR_W    = 6,
   parameter int MAX_INSTR = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_type,
   input  logic [4:0]        in_func,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_sa,
   input  logic [31:0]       in_imm,
   input  logic              in_stop,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_INSTR);

   instr_fields_t   fields;
   logic [31:0]     word;
   logic            imm_i_err, imm_j_err, imm_bad;
   enc_state_e      state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0] cnt, claimed;
   logic            wr_pend;
   logic [31:0]     wr_word;
   logic [1:0]      code;
   logic            accept, new_session, pend_stop, pend_cap;

   assign fields = '{itype: itype_e'(in_type), func: in_func, rs1: in_rs1,
                     rs2: in_rs2, rd: in_rd, sa: in_sa, imm: in_imm,
                     stop: in_stop};

   instr_pack u_pack (
      .f         (fields),
      .word      (word),
      .imm_i_err (imm_i_err),
      .imm_j_err (imm_j_err)
   );

   assign imm_bad = imm_i_err | imm_j_err;

   // A word waiting in the write register already occupies a slot, so it is
   // counted when deciding whether another bundle may be taken.
   assign claimed   = cnt + (ADDR_W+1)'(wr_pend);
   assign pend_stop = wr_pend & wr_word[STOP_BIT];
   assign pend_cap  = wr_pend & ~wr_word[STOP_BIT] & (claimed == MAX_CNT);

   assign in_ready    = (state == S_RUN) && !pend_stop && (claimed < MAX_CNT);
   assign accept      = in_valid & in_ready;
   assign new_session = start & (state != S_RUN);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next state: session ends on the edge that completes the stop/last write,
   // or immediately on acceptance of an out-of-range immediate.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_RUN;
         S_RUN: begin
            if (accept && imm_bad) state_nxt = S_ERR;
            else if (pend_stop)    state_nxt = S_DONE;
            else if (pend_cap)     state_nxt = S_ERR;
         end
      endcase
   end

   // Write register, address, count and error code
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_pend <= 1'b0;
         wr_word <= '0;
         addr    <= '0;
         cnt     <= '0;
         code    <= ERR_NONE;
      end else begin
         wr_pend <= accept & ~imm_bad;
         if (accept && !imm_bad) wr_word <= word;
         if (new_session) begin
            addr <= base_addr;
            cnt  <= '0;
            code <= ERR_NONE;
         end else begin
            if (wr_pend) begin
               addr <= addr + ADDR_W'(1);   // wraps mod 2**ADDR_W
               cnt  <= cnt + (ADDR_W+1)'(1);
            end
            if (accept && imm_bad) code <= imm_i_err ? ERR_IMM_I : ERR_IMM_J;
            else if (pend_cap)     code <= ERR_CAP;
         end
      end
   end

   assign mem_we    = wr_pend;
   assign mem_addr  = addr;
   assign mem_wdata = wr_word;
   assign count     = cnt;
   assign busy      = (state == S_RUN);
   assign done      = (state == S_DONE);
   assign err       = (state == S_ERR);
   assign err_code  = code;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench. The driver predicts each write from an
// arithmetic model of the word format and queues it; a negedge monitor pops
// and compares whenever mem_we is seen.
module tb_instr_encoder;

   localparam int AW   = 6;
   localparam int MAXI = 8;

   logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          in_valid = 1'b0, in_ready, in_stop = 1'b0;
   logic [1:0]    in_type = '0;
   logic [4:0]    in_func = '0, in_rs1 = '0, in_rs2 = '0, in_rd = '0, in_sa = '0;
   logic [31:0]   in_imm = '0;
   logic          mem_we, busy, done, err;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [AW:0]   count;
   logic [1:0]    err_code;

   instr_encoder #(.ADDR_W(AW), .MAX_INSTR(MAXI)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
      .in_func(in_func), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_sa(in_sa), .in_imm(in_imm), .in_stop(in_stop),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .count(count), .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   typedef struct { int t; int func; int rs1; int rs2; int rd; int sa; int imm; bit stop; } bnd_t;
   typedef struct { int addr; logic [31:0] data; } wr_t;

   bnd_t stim[$];
   wr_t  sb[$];
   int   n_cmp = 0, n_bad = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint umod(input longint v, input longint m);
      return ((v % m) + m) % m;
   endfunction

   // Word built by place-value arithmetic from the format table
   function automatic logic [31:0] ref_word(input bnd_t b);
      longint w;
      w = longint'(b.func) * 134217728 + longint'(b.t) * 2 + longint'(b.stop);
      case (b.t)
         0: w += longint'(b.rs1) * 4194304 + longint'(b.rd) * 131072 + longint'(b.rs2) * 4096;
         1: w += umod(longint'(b.imm), 16777216) * 8;
         2: w += longint'(b.rs1) * 4194304 + longint'(b.rd) * 131072 + umod(longint'(b.imm), 16384) * 8;
         default: w += longint'(b.rs1) * 4194304 + longint'(b.rd) * 131072 +
                       longint'(b.rs2) * 4096 + longint'(b.sa) * 128;
      endcase
      return w[31:0];
   endfunction

   function automatic int ref_err(input bnd_t b);
      if (b.t == 2 && (b.imm < -8192 || b.imm > 8191)) return 1;
      if (b.t == 1 && (b.imm < -8388608 || b.imm > 8388607)) return 2;
      return 0;
   endfunction

   function automatic bnd_t mk(input int t, input int func, input int rs1, input int rs2,
                               input int rd, input int sa, input int imm, input bit stop);
      bnd_t b;
      b.t = t; b.func = func; b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.sa = sa;
      b.imm = imm; b.stop = stop;
      return b;
   endfunction

   function automatic bnd_t rnd_bnd(input bit allow_bad);
      bnd_t b;
      int   lim;
      b = mk($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 0, 1'b0);
      lim = (b.t == 2) ? 8192 : 8388608;
      case ($urandom_range(0, allow_bad ? 5 : 2))
         0: b.imm = int'($urandom_range(0, 2 * lim - 1)) - lim;
         1: b.imm = lim - 1;
         2: b.imm = -lim;
         3: b.imm = lim;
         4: b.imm = -lim - 1;
         default: b.imm = int'($urandom);
      endcase
      return b;
   endfunction

   task automatic drive(input bnd_t b);
      in_type = 2'(b.t);  in_func = 5'(b.func); in_rs1 = 5'(b.rs1); in_rs2 = 5'(b.rs2);
      in_rd = 5'(b.rd);   in_sa = 5'(b.sa);     in_imm = b.imm;     in_stop = b.stop;
   endtask

   task automatic chk_reset_outs(input string name);
      chk(name, {in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, err, err_code}, 0);
   endtask

   // Runs one session over stim[]; the model decides acceptance and outcome.
   task automatic run_session(input int base, input bit idles);
      int m_addr = base, m_cnt = 0, code_e = 0, e;
      bit active = 1, done_e = 0, err_e = 0;
      start = 1'b1; base_addr = AW'(base);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("count_after_start", count, 0);
      foreach (stim[i]) begin
         if (idles && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         drive(stim[i]);
         in_valid = 1'b1;
         chk("in_ready", in_ready, active);
         if (active) begin
            e = ref_err(stim[i]);
            if (e != 0) begin
               active = 0; err_e = 1; code_e = e;
            end else begin
               sb.push_back('{m_addr % (2 ** AW), ref_word(stim[i])});
               m_addr++; m_cnt++;
               if (stim[i].stop) begin
                  active = 0; done_e = 1;
               end else if (m_cnt == MAXI) begin
                  active = 0; err_e = 1; code_e = 3;
               end
            end
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("count", count, m_cnt);
      chk("done", done, done_e);
      chk("err", err, err_e);
      chk("err_code", err_code, code_e);
      chk("busy_end", busy, active);
      chk("writes_outstanding", sb.size(), 0);
      sb.delete();
   endtask

   // Monitor: every observed write must match the oldest prediction
   always @(negedge clk) begin
      if (!reset && mem_we) begin
         if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", mem_addr, mem_wdata);
         end else begin
            wr_t w;
            w = sb.pop_front();
            chk("wr_addr", mem_addr, w.addr);
            chk("wr_data", mem_wdata, w.data);
         end
      end
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk_reset_outs("reset_outputs");
      reset = 1'b0;
      // Valid while idle must be ignored (monitor flags any write)
      drive(mk(0, 1, 1, 1, 1, 0, 0, 1'b1));
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_ready", in_ready, 0);
      in_valid = 1'b0;

      stim = '{mk(0, 3, 1, 4, 2, 0, 0, 1'b0), mk(3, 7, 9, 10, 11, 12, 0, 1'b1)};
      run_session(0, 0);
      stim = '{mk(2, 1, 5, 0, 6, 0, -1, 1'b0), mk(1, 2, 0, 0, 0, 0, 'h10, 1'b1)};
      run_session(0, 0);
      stim = '{mk(2, 4, 1, 2, 3, 0, 8192, 1'b0), mk(0, 1, 1, 1, 1, 1, 0, 1'b1)};
      run_session(3, 0);
      stim = '{mk(1, 4, 0, 0, 0, 0, -8388609, 1'b1), mk(0, 1, 1, 1, 1, 1, 0, 1'b1)};
      run_session(3, 0);
      stim.delete();
      for (int i = 0; i <= MAXI; i++) stim.push_back(mk(0, i, i, i + 1, i + 2, 0, 0, 1'b0));
      run_session(20, 0);
      stim = '{mk(0, 9, 8, 7, 6, 0, 0, 1'b0), mk(2, 5, 4, 0, 3, 0, -8192, 1'b1)};
      run_session(63, 0);

      // Reset in the cycle after acceptance drops the pending write
      start = 1'b1; base_addr = AW'(10);
      @(negedge clk);
      start = 1'b0;
      drive(mk(0, 3, 1, 4, 2, 0, 0, 1'b0));
      in_valid = 1'b1;
      @(posedge clk);
      #1 reset = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk_reset_outs("mid_reset_outputs");
      reset = 1'b0;
      @(negedge clk);
      stim = '{mk(0, 1, 2, 3, 4, 0, 0, 1'b0), mk(1, 6, 0, 0, 0, 0, -8388608, 1'b1)};
      run_session(5, 0);

      // Randomized sessions, some long enough to hit capacity
      for (int s = 0; s < 25; s++) begin
         stim.delete();
         n = $urandom_range(1, MAXI + 2);
         for (int k = 0; k < n; k++) stim.push_back(rnd_bnd($urandom_range(0, 3) == 0));
         if (n <= MAXI) stim[n-1].stop = 1'b1;
         run_session($urandom_range(0, 2 ** AW - 1), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
